pmod_cmd_rx: RTL and testbench



---
 rtl/pmod_cmd_rx.sv | 133 +++++++++++++
 tb/tb_pmod_cmd_rx.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmod_cmd_rx.sv
// PMOD move-code receiver: synchronise, debounce, detect idle-to-move commands
// and queue them in a small FIFO whose head is presented as {valid, code}.
module pmod_cmd_rx #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned CNT_W           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic [3:0]       PMOD_IN,
  input  logic             IO_START,
  input  logic             IO_DONE,
  output logic [4:0]       IO_PMOD,
  output logic             OVERFLOW,
  output logic [CNT_W-1:0] FIFO_COUNT
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] CntMax = DW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       cand_q, cand_d;
  logic [DW-1:0]    cnt_q, cnt_d;
  logic [3:0]       stable_q, stable_d;
  logic [3:0]       stable_prev_q;
  logic             done_q, start_q;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [3:0]       mem_q [FIFO_DEPTH];
  logic [3:0]       mem_d [FIFO_DEPTH];
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic          push_req, pop_req, start_rise;
  logic          empty, full;
  logic          do_push, do_pop;
  logic [AW-1:0] wr_idx, rd_idx;

  // Debouncer: a code must sit unchanged for DEBOUNCE_CYCLES edges before it is adopted.
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + DW'(1);
    end else begin
      stable_d = cand_q;
    end
  end

  assign push_req   = (stable_prev_q == 4'h0) && (stable_q != 4'h0);
  assign pop_req    = IO_DONE & ~done_q;
  assign start_rise = IO_START & ~start_q;

  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop_req & ~empty;
  assign do_push = push_req & IO_START & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_idx] = stable_q;
      wr_ptr_d      = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = CNT_W'(wr_ptr_d - rd_ptr_d);
  end

  always_comb begin
    ovf_d = ovf_q;
    if (start_rise) begin
      ovf_d = 1'b0;
    end
    if (push_req && IO_START && full && !do_pop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      cand_q        <= '0;
      cnt_q         <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      done_q        <= 1'b0;
      start_q       <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      ovf_q         <= 1'b0;
      count_q       <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      sync1_q       <= PMOD_IN;
      sync2_q       <= sync1_q;
      cand_q        <= cand_d;
      cnt_q         <= cnt_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      done_q        <= IO_DONE;
      start_q       <= IO_START;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      ovf_q         <= ovf_d;
      count_q       <= count_d;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign IO_PMOD    = empty ? 5'h00 : {1'b1, mem_q[rd_idx]};
  assign OVERFLOW   = ovf_q;
  assign FIFO_COUNT = count_q;

endmodule

// File: tb/tb_pmod_cmd_rx.sv
// Bench for pmod_cmd_rx: directed scenarios plus randomized command/pop traffic
// checked against a transaction-level queue model.
module tb_pmod_cmd_rx;

  logic       HCLK;
  logic       HRESETn;
  logic [3:0] PMOD_IN;
  logic       IO_START;
  logic       IO_DONE;
  logic [4:0] IO_PMOD;
  logic       OVERFLOW;
  logic [2:0] FIFO_COUNT;

  int vectors     = 0;
  int miscompares = 0;

  logic [3:0] mq[$];
  bit         m_ovf;

  pmod_cmd_rx #(
    .DEBOUNCE_CYCLES(4),
    .FIFO_DEPTH     (4)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .PMOD_IN   (PMOD_IN),
    .IO_START  (IO_START),
    .IO_DONE   (IO_DONE),
    .IO_PMOD   (IO_PMOD),
    .OVERFLOW  (OVERFLOW),
    .FIFO_COUNT(FIFO_COUNT)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    @(negedge HCLK);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Transaction-level model: a debounced idle-to-move command enqueues when enabled.
  task automatic m_push(input logic [3:0] code);
    if (IO_START) begin
      if (mq.size() < 4) mq.push_back(code);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic m_pop();
    if (mq.size() > 0) void'(mq.pop_front());
  endtask

  function automatic logic [7:0] m_pmod();
    if (mq.size() == 0) return 8'h00;
    return {3'b000, 1'b1, mq[0]};
  endfunction

  task automatic chk_model(input string tag);
    chk({tag, "_pmod"}, {3'b000, IO_PMOD}, m_pmod());
    chk({tag, "_count"}, {5'b0, FIFO_COUNT}, 8'(mq.size()));
    chk({tag, "_ovf"}, {7'b0, OVERFLOW}, {7'b0, m_ovf});
  endtask

  task automatic cmd(input logic [3:0] code, input int hold, input int gap);
    PMOD_IN = code;
    repeat (hold) tick();
    PMOD_IN = 4'h0;
    repeat (gap) tick();
    m_push(code);
  endtask

  task automatic pop(input int hold);
    IO_DONE = 1'b1;
    repeat (hold) tick();
    IO_DONE = 1'b0;
    tick();
    m_pop();
  endtask

  initial begin
    HRESETn  = 1'b0;
    PMOD_IN  = 4'h0;
    IO_START = 1'b1;
    IO_DONE  = 1'b0;
    m_ovf    = 1'b0;
    repeat (2) tick();
    chk("rst_pmod", {3'b0, IO_PMOD}, 8'h00);
    chk("rst_count", {5'b0, FIFO_COUNT}, 8'h00);
    chk("rst_ovf", {7'b0, OVERFLOW}, 8'h00);
    HRESETn = 1'b1;
    repeat (3) tick();

    // Single command: visible after edge 8, not at edge 7.
    PMOD_IN = 4'h5;
    repeat (7) tick();
    chk("lat_edge7", {3'b0, IO_PMOD}, 8'h00);
    tick();
    chk("lat_edge8_pmod", {3'b0, IO_PMOD}, 8'h15);
    chk("lat_edge8_count", {5'b0, FIFO_COUNT}, 8'h01);
    repeat (12) tick();
    PMOD_IN = 4'h0;
    repeat (10) tick();
    m_push(4'h5);
    chk_model("single");
    pop(1);
    chk("single_pop_pmod", {3'b0, IO_PMOD}, 8'h00);
    chk_model("single_pop");

    // Glitch shorter than the debounce window.
    PMOD_IN = 4'h7;
    repeat (3) tick();
    PMOD_IN = 4'h0;
    repeat (10) tick();
    chk_model("glitch");

    // Overflow then drain; a held-high IO_DONE pops only once.
    cmd(4'h1, 10, 10);
    cmd(4'h2, 10, 10);
    cmd(4'h3, 10, 10);
    cmd(4'h4, 10, 10);
    cmd(4'h6, 10, 10);
    chk("ovf_count", {5'b0, FIFO_COUNT}, 8'h04);
    chk("ovf_pmod", {3'b0, IO_PMOD}, 8'h11);
    chk("ovf_flag", {7'b0, OVERFLOW}, 8'h01);
    pop(3);
    chk("drain1", {3'b0, IO_PMOD}, 8'h12);
    chk_model("drain1");
    pop(1);
    chk("drain2", {3'b0, IO_PMOD}, 8'h13);
    pop(1);
    chk("drain3", {3'b0, IO_PMOD}, 8'h14);
    pop(1);
    chk("drain4", {3'b0, IO_PMOD}, 8'h00);
    chk("drain_ovf_held", {7'b0, OVERFLOW}, 8'h01);
    IO_START = 1'b0;
    tick();
    chk("ovf_start_low", {7'b0, OVERFLOW}, 8'h01);
    IO_START = 1'b1;
    tick();
    m_ovf = 1'b0;
    chk("ovf_start_rise", {7'b0, OVERFLOW}, 8'h00);

    // Nonzero-to-nonzero change queues only the first code.
    PMOD_IN = 4'h3;
    repeat (10) tick();
    PMOD_IN = 4'h9;
    repeat (10) tick();
    PMOD_IN = 4'h0;
    repeat (10) tick();
    m_push(4'h3);
    chk("noidle_pmod", {3'b0, IO_PMOD}, 8'h13);
    chk_model("noidle");
    pop(1);

    // Gated push is discarded.
    IO_START = 1'b0;
    cmd(4'hA, 12, 10);
    chk_model("gated");
    IO_START = 1'b1;
    tick();

    // Pop on empty.
    pop(1);
    chk("empty_pop_count", {5'b0, FIFO_COUNT}, 8'h00);

    // Full FIFO: push of 8 coincides with a pop.
    cmd(4'h1, 10, 10);
    cmd(4'h2, 10, 10);
    cmd(4'h3, 10, 10);
    cmd(4'h4, 10, 10);
    chk_model("full_pre");
    PMOD_IN = 4'h8;
    repeat (7) tick();
    IO_DONE = 1'b1;
    tick();
    m_pop();
    m_push(4'h8);
    IO_DONE = 1'b0;
    chk("simfull_count", {5'b0, FIFO_COUNT}, 8'h04);
    chk("simfull_pmod", {3'b0, IO_PMOD}, 8'h12);
    chk("simfull_ovf", {7'b0, OVERFLOW}, 8'h00);
    repeat (5) tick();
    PMOD_IN = 4'h0;
    repeat (10) tick();
    pop(1);
    pop(1);
    pop(1);
    chk("simfull_tail", {3'b0, IO_PMOD}, 8'h18);
    pop(1);
    chk_model("simfull_drained");

    // Empty FIFO: same coincidence, the pop is ignored.
    PMOD_IN = 4'h8;
    repeat (7) tick();
    IO_DONE = 1'b1;
    tick();
    m_pop();
    m_push(4'h8);
    IO_DONE = 1'b0;
    chk("simempty_count", {5'b0, FIFO_COUNT}, 8'h01);
    chk("simempty_pmod", {3'b0, IO_PMOD}, 8'h18);
    repeat (5) tick();
    PMOD_IN = 4'h0;
    repeat (10) tick();
    pop(1);
    chk_model("simempty_drained");

    // Reset between edges with entries queued and code 5 mid-debounce.
    cmd(4'h2, 10, 10);
    cmd(4'h3, 10, 10);
    chk("prereset_count", {5'b0, FIFO_COUNT}, 8'h02);
    PMOD_IN = 4'h5;
    repeat (3) tick();
    #2 HRESETn = 1'b0;
    #1;
    chk("midrst_pmod", {3'b0, IO_PMOD}, 8'h00);
    chk("midrst_ovf", {7'b0, OVERFLOW}, 8'h00);
    chk("midrst_count", {5'b0, FIFO_COUNT}, 8'h00);
    mq.delete();
    m_ovf = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (12) tick();
    m_push(4'h5);
    chk("postrst_pmod", {3'b0, IO_PMOD}, 8'h15);
    repeat (10) tick();
    chk_model("postrst_once");
    PMOD_IN = 4'h0;
    repeat (10) tick();
    pop(1);
    chk_model("postrst_drained");

    // Randomized traffic against the queue model.
    for (int i = 0; i < 40; i++) begin
      int unsigned act;
      act = $urandom_range(0, 9);
      if (act < 5) begin
        cmd(4'($urandom_range(1, 15)), int'($urandom_range(9, 16)),
            int'($urandom_range(10, 14)));
      end else if (act < 7) begin
        pop(int'($urandom_range(1, 3)));
      end else if (act < 8) begin
        PMOD_IN = 4'($urandom_range(1, 15));
        repeat ($urandom_range(1, 3)) tick();
        PMOD_IN = 4'h0;
        repeat (10) tick();
      end else begin
        IO_START = 1'b0;
        cmd(4'($urandom_range(1, 15)), 12, 10);
        IO_START = 1'b1;
        tick();
        m_ovf = 1'b0;
      end
      chk_model("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
